// File: rtl/psram_rx_path_pkg.sv
// Shared definitions for the PSRAM read-data capture path:
// FSM state encodings, word width and the byte-lane insert helper.
package psram_rx_path_pkg;

   localparam int PSRAM_RX_WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      PSRAM_RX_IDLE = 2'd0,
      PSRAM_RX_SKIP = 2'd1,
      PSRAM_RX_DATA = 2'd2
   } rx_state_e;

   // Replace byte lane idx of a little-endian word with b.
   function automatic logic [PSRAM_RX_WORD_WIDTH-1:0] insert_byte(
      input logic [PSRAM_RX_WORD_WIDTH-1:0] w,
      input logic [1:0]                     idx,
      input logic [7:0]                     b
   );
      logic [PSRAM_RX_WORD_WIDTH-1:0] r;
      r = w;
      r[8*idx +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/psram_rx_fifo.sv
// Synchronous word FIFO with flush; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module psram_rx_fifo
   import psram_rx_path_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = PSRAM_RX_WORD_WIDTH
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clr_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       empty_o,
   output logic                       drop_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      level;
   logic             full;
   logic             pop_ok;
   logic             push_ok;

   always_comb begin
      full    = (level == (AW+1)'(DEPTH));
      empty_o = (level == '0);
      pop_ok  = pop_i && !empty_o;
      push_ok = push_i && (!full || pop_ok);
      drop_o  = push_i && full && !pop_ok && !clr_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clr_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= data_i;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

   assign data_o  = mem[rd_ptr];
   assign level_o = level;

endmodule

// File: rtl/psram_rx_path.sv
// PSRAM read capture: detects SCK edges, skips cmd/addr/wait edges,
// packs data bytes little-endian into words and queues them in a FIFO.
module psram_rx_path
   import psram_rx_path_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            start_i,
   input  logic [LEN_WIDTH-1:0]            skip_i,
   input  logic [LEN_WIDTH-1:0]            len_i,
   input  logic                            clr_i,
   input  logic                            psram_sck_i,
   input  logic                            psram_ce_i,
   input  logic [7:0]                      psram_io_in_i,
   input  logic                            pop_i,
   output logic [PSRAM_RX_WORD_WIDTH-1:0]  data_o,
   output logic                            valid_o,
   output logic [$clog2(FIFO_DEPTH):0]     level_o,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            ovf_o,
   output logic                            err_o
);

   rx_state_e                       state;
   logic                            sck_prev;
   logic                            sck_edge;
   logic [LEN_WIDTH-1:0]            skip_len;
   logic [LEN_WIDTH-1:0]            data_len;
   logic [LEN_WIDTH-1:0]            skip_cnt;
   logic [LEN_WIDTH-1:0]            byte_cnt;
   logic [LEN_WIDTH-1:0]            skip_cnt_nxt;
   logic [LEN_WIDTH-1:0]            byte_cnt_nxt;
   logic [PSRAM_RX_WORD_WIDTH-1:0]  word;
   logic [PSRAM_RX_WORD_WIDTH-1:0]  word_nxt;
   logic                            push;
   logic [PSRAM_RX_WORD_WIDTH-1:0]  push_word;
   logic                            fifo_empty;
   logic                            fifo_drop;

   // Counters saturate so a huge length can never wrap back onto a match.
   always_comb begin
      sck_edge     = psram_sck_i ^ sck_prev;
      skip_cnt_nxt = (skip_cnt == '1) ? skip_cnt : skip_cnt + LEN_WIDTH'(1);
      byte_cnt_nxt = (byte_cnt == '1) ? byte_cnt : byte_cnt + LEN_WIDTH'(1);
      word_nxt     = insert_byte(word, byte_cnt[1:0], psram_io_in_i);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= PSRAM_RX_IDLE;
         sck_prev  <= 1'b0;
         skip_len  <= '0;
         data_len  <= '0;
         skip_cnt  <= '0;
         byte_cnt  <= '0;
         word      <= '0;
         push      <= 1'b0;
         push_word <= '0;
         done_o    <= 1'b0;
         err_o     <= 1'b0;
         ovf_o     <= 1'b0;
      end else begin
         sck_prev <= psram_sck_i;
         push     <= 1'b0;
         done_o   <= 1'b0;
         case (state)
            PSRAM_RX_IDLE: begin
               if (start_i) begin
                  skip_len <= skip_i;
                  data_len <= len_i;
                  skip_cnt <= '0;
                  byte_cnt <= '0;
                  word     <= '0;
                  if (len_i == '0) begin
                     done_o <= 1'b1;
                  end else if (skip_i == '0) begin
                     state <= PSRAM_RX_DATA;
                  end else begin
                     state <= PSRAM_RX_SKIP;
                  end
               end
            end
            PSRAM_RX_SKIP: begin
               if (psram_ce_i) begin
                  state  <= PSRAM_RX_IDLE;
                  err_o  <= 1'b1;
                  done_o <= 1'b1;
               end else if (sck_edge) begin
                  skip_cnt <= skip_cnt_nxt;
                  if (skip_cnt_nxt == skip_len) begin
                     state <= PSRAM_RX_DATA;
                  end
               end
            end
            PSRAM_RX_DATA: begin
               if (psram_ce_i) begin
                  state  <= PSRAM_RX_IDLE;
                  word   <= '0;
                  err_o  <= 1'b1;
                  done_o <= 1'b1;
               end else if (sck_edge) begin
                  byte_cnt <= byte_cnt_nxt;
                  if (byte_cnt[1:0] == 2'd3 || byte_cnt_nxt == data_len) begin
                     push      <= 1'b1;
                     push_word <= word_nxt;
                     word      <= '0;
                  end else begin
                     word <= word_nxt;
                  end
                  if (byte_cnt_nxt == data_len) begin
                     done_o <= 1'b1;
                     state  <= PSRAM_RX_IDLE;
                  end
               end
            end
            default: state <= PSRAM_RX_IDLE;
         endcase
         // Flush wins over any sticky set in the same cycle.
         if (clr_i) begin
            err_o <= 1'b0;
            ovf_o <= 1'b0;
         end else if (fifo_drop) begin
            ovf_o <= 1'b1;
         end
      end
   end

   psram_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PSRAM_RX_WORD_WIDTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (clr_i),
      .push_i  (push),
      .data_i  (push_word),
      .pop_i   (pop_i),
      .data_o  (data_o),
      .level_o (level_o),
      .empty_o (fifo_empty),
      .drop_o  (fifo_drop)
   );

   assign valid_o = !fifo_empty;
   assign busy_o  = (state != PSRAM_RX_IDLE);

endmodule

// File: tb/tb_psram_rx_path.sv
// Directed-vector bench for psram_rx_path with hand-computed expectations.
module tb_psram_rx_path;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  skip;
   logic [7:0]  len;
   logic        clr;
   logic        sck;
   logic        ce;
   logic [7:0]  io;
   logic        pop;
   logic [31:0] data;
   logic        valid;
   logic [2:0]  level;
   logic        busy;
   logic        done;
   logic        ovf;
   logic        err;

   int n_vec = 0;
   int n_mis = 0;
   int done_total = 0;
   int d0;

   psram_rx_path #(.FIFO_DEPTH(4), .LEN_WIDTH(8)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .skip_i        (skip),
      .len_i         (len),
      .clr_i         (clr),
      .psram_sck_i   (sck),
      .psram_ce_i    (ce),
      .psram_io_in_i (io),
      .pop_i         (pop),
      .data_o        (data),
      .valid_o       (valid),
      .level_o       (level),
      .busy_o        (busy),
      .done_o        (done),
      .ovf_o         (ovf),
      .err_o         (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_total++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_edge(input logic [7:0] b);
      io  = b;
      sck = ~sck;
      tick();
      tick();
   endtask

   task automatic begin_rd(input logic [7:0] s, input logic [7:0] l);
      skip  = s;
      len   = l;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pop_one();
      pop = 1'b1;
      tick();
      pop = 1'b0;
   endtask

   task automatic flush();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; skip = 8'd0; len = 8'd0; clr = 1'b0;
      sck = 1'b0; ce = 1'b1; io = 8'd0; pop = 1'b0;
      repeat (3) tick();
      chk("rst_data",  data,  32'h0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_level", {29'd0, level}, 32'd0);
      chk("rst_busy",  {31'd0, busy},  32'd0);
      chk("rst_done",  {31'd0, done},  32'd0);
      chk("rst_flags", {30'd0, ovf, err}, 32'd0);
      rst = 1'b0;
      ce  = 1'b0;
      tick();

      // 1: skip 12 edges, then 4 data bytes
      d0 = done_total;
      begin_rd(8'd12, 8'd4);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 16; i++) do_edge(8'(i));
      chk("t1_word",  data, 32'h0F0E0D0C);
      chk("t1_level", {29'd0, level}, 32'd1);
      chk("t1_done",  32'(done_total - d0), 32'd1);
      chk("t1_busy_end", {31'd0, busy}, 32'd0);
      pop_one();

      // 2: no skip, 6 bytes -> full word then zero-padded partial
      begin_rd(8'd0, 8'd6);
      for (int i = 0; i < 6; i++) do_edge(8'hA0 + 8'(i));
      chk("t2_level", {29'd0, level}, 32'd2);
      chk("t2_w0", data, 32'hA3A2A1A0);
      pop_one();
      chk("t2_w1", data, 32'h0000A5A4);
      pop_one();
      chk("t2_valid", {31'd0, valid}, 32'd0);

      // 3: overflow with 20 bytes and no pops, then flush
      begin_rd(8'd0, 8'd20);
      for (int i = 0; i < 20; i++) do_edge(8'h40 + 8'(i));
      tick();
      chk("t3_level", {29'd0, level}, 32'd4);
      chk("t3_ovf",   {31'd0, ovf}, 32'd1);
      chk("t3_head",  data, 32'h43424140);
      chk("t3_err",   {31'd0, err}, 32'd0);
      flush();
      chk("t3_clr_level", {29'd0, level}, 32'd0);
      chk("t3_clr_ovf",   {31'd0, ovf}, 32'd0);

      // 4: CE abort after 6 of 8 bytes
      d0 = done_total;
      begin_rd(8'd0, 8'd8);
      for (int i = 0; i < 6; i++) do_edge(8'h60 + 8'(i));
      ce = 1'b1;
      tick();
      tick();
      chk("t4_level", {29'd0, level}, 32'd1);
      chk("t4_word",  data, 32'h63626160);
      chk("t4_err",   {31'd0, err}, 32'd1);
      chk("t4_done",  32'(done_total - d0), 32'd1);
      chk("t4_busy",  {31'd0, busy}, 32'd0);
      ce = 1'b0;
      flush();
      chk("t4_clr_err", {31'd0, err}, 32'd0);

      // 5: full FIFO with simultaneous push and pop
      begin_rd(8'd0, 8'd16);
      for (int i = 0; i < 16; i++) do_edge(8'h10 + 8'(i));
      chk("t5_full", {29'd0, level}, 32'd4);
      begin_rd(8'd0, 8'd4);
      for (int i = 0; i < 3; i++) do_edge(8'h20 + 8'(i));
      io  = 8'h23;
      sck = ~sck;
      tick();
      pop = 1'b1;
      tick();
      pop = 1'b0;
      chk("t5_level", {29'd0, level}, 32'd4);
      chk("t5_ovf",   {31'd0, ovf}, 32'd0);
      chk("t5_head0", data, 32'h17161514);
      pop_one();
      chk("t5_head1", data, 32'h1B1A1918);
      pop_one();
      chk("t5_head2", data, 32'h1F1E1D1C);
      pop_one();
      chk("t5_head3", data, 32'h23222120);
      pop_one();
      chk("t5_empty", {29'd0, level}, 32'd0);
      pop_one();
      chk("t5_pop_empty_level", {29'd0, level}, 32'd0);
      chk("t5_pop_empty_valid", {31'd0, valid}, 32'd0);

      // 6: start while busy ignored; len 0; async reset mid-DATA
      d0 = done_total;
      begin_rd(8'd0, 8'd4);
      do_edge(8'h30);
      do_edge(8'h31);
      begin_rd(8'd5, 8'd0);
      do_edge(8'h32);
      do_edge(8'h33);
      chk("t6_ign_word", data, 32'h33323130);
      chk("t6_ign_done", 32'(done_total - d0), 32'd1);
      begin_rd(8'd3, 8'd0);
      chk("t6_len0_done", {31'd0, done}, 32'd1);
      chk("t6_len0_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("t6_len0_pulse", {31'd0, done}, 32'd0);
      chk("t6_len0_level", {29'd0, level}, 32'd1);
      begin_rd(8'd0, 8'd8);
      for (int i = 0; i < 5; i++) do_edge(8'h50 + 8'(i));
      chk("t6_pre_busy", {31'd0, busy}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_busy",  {31'd0, busy},  32'd0);
      chk("t6_rst_level", {29'd0, level}, 32'd0);
      chk("t6_rst_valid", {31'd0, valid}, 32'd0);
      chk("t6_rst_data",  data, 32'h0);
      chk("t6_rst_flags", {29'd0, done, ovf, err}, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/psram_rx_path.md
Name: psram_rx_path

Overview:
- Read-data capture stage directly downstream of the PSRAM controller core's pad interface.
- Watches the controller-driven psram_sck/psram_ce and samples psram_io_in on every SCK edge (OPI DDR, one byte per edge).
- Discards the command/address/wait edges, packs the data bytes little-endian into 32-bit words, and buffers them in a small FIFO for the register/bus side to pop.
- Reports completion and errors back to the controller/register file.

Parameters:
- FIFO_DEPTH, 4, number of 32-bit words in the RX FIFO; power of 2, at least 2.
- LEN_WIDTH, 8, width of the byte-length and skip-count inputs.

Ports:
- clk_i  in  1  system clock; the same clock that generates psram_sck.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse: a read transaction begins (issued with CE assertion).
- skip_i  in  LEN_WIDTH  number of SCK edges to discard before data (cmd+addr+wait).
- len_i  in  LEN_WIDTH  number of data bytes to capture.
- clr_i  in  1  clears sticky ovf_o/err_o and flushes the FIFO.
- psram_sck_i  in  1  SCK as driven by the controller.
- psram_ce_i  in  1  CE, active-low.
- psram_io_in_i  in  8  pad input data.
- pop_i  in  1  read strobe for the FIFO head.
- data_o  out  32  FIFO head word; valid when valid_o=1.
- valid_o  out  1  FIFO not empty.
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse at transaction end (normal or aborted).
- ovf_o  out  1  sticky: a word was dropped because the FIFO was full.
- err_o  out  1  sticky: CE deasserted before len_i bytes were captured.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, sck_prev=0.
- Edge strobe: edge = psram_sck_i ^ sck_prev, with sck_prev registered every cycle. A byte is sampled from psram_io_in_i in the edge cycle.
- States: IDLE, SKIP, DATA.
  - IDLE: on start_i, latch skip_i and len_i.
    - len_i==0: done_o pulses next cycle and the block stays in IDLE.
    - skip_i==0: go to DATA.
    - Otherwise go to SKIP.
  - SKIP: count edges. On the edge that makes the count equal skip_i, go to DATA. That edge is not captured.
  - DATA:
    - Each edge shifts the byte into a word assembler; byte k of the word is at bits [8k+7:8k].
    - After the 4th byte, or after the final byte (byte count == len_i), push the word. Unfilled upper bytes are zero.
    - The push happens in the cycle after the completing edge.
    - After the final byte, done_o pulses in the same cycle as the push and the state returns to IDLE.
- Abort: psram_ce_i==1 in SKIP or DATA returns to IDLE next cycle. The partial word is discarded, err_o is set, and done_o pulses.
- start_i while busy_o=1 is ignored.
- FIFO:
  - Push when full: the word is dropped, ovf_o is set, and the FIFO contents are unchanged.
  - Simultaneous push and pop when full: both succeed and the level is unchanged.
  - pop_i when empty: ignored.
  - data_o is combinational from the head entry.
  - Pointers wrap modulo FIFO_DEPTH; level_o is tracked explicitly.
- clr_i:
  - Empties the FIFO and clears ovf_o/err_o next cycle.
  - If asserted together with a push, clr_i wins and the FIFO ends empty.
  - Does not affect the FSM.
- Counters: skip and byte counters are LEN_WIDTH wide and saturate. There is no wrap within one transaction.
- Reset mid-transaction: immediate return to IDLE; FIFO emptied; stickies cleared.

Decomposition:
- psram_define gains:
  - PSRAM_RX_IDLE/SKIP/DATA state encodings (2-bit).
  - PSRAM_RX_WORD_WIDTH=32.
- One natural sub-module: psram_rx_fifo (sync FIFO with push/pop/clr, full/empty/level), instantiated once.
- Edge detect, FSM, and assembler stay in psram_rx_path.

Test Plan:
1. skip_i=12, len_i=4, 16 SCK edges carrying bytes 0..15 -> one word 0x0F0E0D0C pushed; done_o pulses once; level_o=1.
2. skip_i=0, len_i=6, bytes A0..A5 -> words 0xA3A2A1A0 and 0x0000A5A4; pop twice returns them in order; valid_o drops to 0.
3. len_i=20 with FIFO_DEPTH=4 and no pops -> 4 words stored, 5th dropped; ovf_o=1. Then clr_i -> level_o=0, ovf_o=0.
4. CE driven high after 6 data bytes of len_i=8 -> one word stored, partial 2 bytes discarded; err_o=1; done_o pulses; busy_o=0.
5. FIFO full with push and pop in the same cycle -> level_o stays 4; head advances; ovf_o stays 0. Also: pop_i on empty FIFO -> no change.
6. start_i during busy is ignored; len_i=0 -> done_o one cycle after start_i with no push. rst_i asserted mid-DATA -> all outputs 0 asynchronously.
